// File: rtl/jtag_tap_multi_if.sv
// Bundle between the TAP and the user data-register logic: shared test clock/data,
// TAP state strobes, per-channel selects and serial returns.
interface jtag_tap_multi_if #(
  parameter int unsigned IrLength = 5,
  parameter int unsigned NumDr    = 2
);
  logic                tck_o;
  logic                tdi_o;
  logic                capture_o;
  logic                shift_o;
  logic                update_o;
  logic                tlr_o;
  logic [NumDr-1:0]    dr_select_o;
  logic [NumDr-1:0]    dr_tdo_i;
  logic [IrLength-1:0] ir_o;

  modport master (
    output tck_o, tdi_o, capture_o, shift_o, update_o, tlr_o, dr_select_o, ir_o,
    input  dr_tdo_i
  );

  modport slave (
    input  tck_o, tdi_o, capture_o, shift_o, update_o, tlr_o, dr_select_o, ir_o,
    output dr_tdo_i
  );
endinterface

// File: rtl/tc_clk_inverter.sv
// Clock inverter cell wrapper.
module tc_clk_inverter (
  input  logic clk_i,
  output logic clk_o
);
  assign clk_o = ~clk_i;
endmodule

// File: rtl/tc_clk_mux2.sv
// Two-input clock mux cell wrapper; clk_sel_i = 1 selects clk1_i.
module tc_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);
  assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1 TAP controller with configurable IR, IDCODE, bypass and NumDr user DR channels.
module jtag_tap_multi #(
  parameter int unsigned         IrLength          = 5,
  parameter int unsigned         NumDr             = 2,
  parameter logic [IrLength-1:0] DrOpcodes [NumDr] = '{5'h11, 5'h10},
  parameter logic [IrLength-1:0] IdcodeOpcode      = 5'h01,
  parameter logic [31:0]         IdcodeValue       = 32'h0000_0001,
  parameter logic [IrLength-1:0] IrCaptureValue    = 5'b00101
) (
  input  logic             tck_i,
  input  logic             trst_ni,
  input  logic             tms_i,
  input  logic             td_i,
  output logic             td_o,
  output logic             tdo_oe_o,
  input  logic             testmode_i,
  jtag_tap_multi_if.master dr_if
);

  localparam int unsigned IdcodeWidth = 32;

  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr,
    Exit2Dr, UpdateDr, SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
  } tap_state_e;

  tap_state_e state_q, state_d;

  logic [IrLength-1:0]    ir_shift_q;
  logic [IrLength-1:0]    ir_q;
  logic [IdcodeWidth-1:0] idcode_q;
  logic                   bypass_q;
  logic [NumDr-1:0]       dr_sel;
  logic                   user_hit;
  logic                   idcode_sel;
  logic                   bypass_sel;
  logic                   tdo_mux;
  logic                   tck_n;
  logic                   tck_tdo;

  // TAP state register
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TestLogicReset;
    else          state_q <= state_d;
  end

  // Standard 1149.1 TMS transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  // Instruction register; TestLogicReset wins over UpdateIr
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_shift_q <= '0;
      ir_q       <= IdcodeOpcode;
    end else begin
      if (state_q == CaptureIr)    ir_shift_q <= IrCaptureValue;
      else if (state_q == ShiftIr) ir_shift_q <= {td_i, ir_shift_q[IrLength-1:1]};

      if (state_q == TestLogicReset) ir_q <= IdcodeOpcode;
      else if (state_q == UpdateIr)  ir_q <= ir_shift_q;
    end
  end

  // Opcode decode: lowest matching user channel, then IDCODE, else bypass
  always_comb begin
    dr_sel   = '0;
    user_hit = 1'b0;
    for (int unsigned i = 0; i < NumDr; i++) begin
      if (!user_hit && (ir_q == DrOpcodes[i])) begin
        dr_sel[i] = 1'b1;
        user_hit  = 1'b1;
      end
    end
  end

  assign idcode_sel = !user_hit && (ir_q == IdcodeOpcode);
  assign bypass_sel = !user_hit && !idcode_sel;

  // Internal data registers, each touched only while selected
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_q <= IdcodeValue;
      bypass_q <= 1'b0;
    end else begin
      if (idcode_sel) begin
        if (state_q == CaptureDr)    idcode_q <= IdcodeValue;
        else if (state_q == ShiftDr) idcode_q <= {td_i, idcode_q[IdcodeWidth-1:1]};
      end
      if (bypass_sel) begin
        if (state_q == CaptureDr)    bypass_q <= 1'b0;
        else if (state_q == ShiftDr) bypass_q <= td_i;
      end
    end
  end

  always_comb begin
    tdo_mux = bypass_q;
    if (state_q == ShiftIr) tdo_mux = ir_shift_q[0];
    else if (user_hit)      tdo_mux = |(dr_if.dr_tdo_i & dr_sel);
    else if (idcode_sel)    tdo_mux = idcode_q[0];
  end

  // Falling-edge launch clock; testmode keeps the flops on the true tck for scan
  tc_clk_inverter i_tck_inv (
    .clk_i (tck_i),
    .clk_o (tck_n)
  );

  tc_clk_mux2 i_tck_mux (
    .clk0_i    (tck_n),
    .clk1_i    (tck_i),
    .clk_sel_i (testmode_i),
    .clk_o     (tck_tdo)
  );

  always_ff @(posedge tck_tdo or negedge trst_ni) begin
    if (!trst_ni) begin
      td_o     <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      td_o     <= tdo_mux;
      tdo_oe_o <= (state_q == ShiftIr) || (state_q == ShiftDr);
    end
  end

  assign dr_if.tck_o       = tck_i;
  assign dr_if.tdi_o       = td_i;
  assign dr_if.capture_o   = (state_q == CaptureDr);
  assign dr_if.shift_o     = (state_q == ShiftDr);
  assign dr_if.update_o    = (state_q == UpdateDr);
  assign dr_if.tlr_o       = (state_q == TestLogicReset);
  assign dr_if.dr_select_o = dr_sel;
  assign dr_if.ir_o        = ir_q;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Directed plus randomized scans of jtag_tap_multi against a scan-level reference model.
module tb_jtag_tap_multi;

  localparam logic [4:0]  OpDr0 = 5'h11;
  localparam logic [4:0]  OpDr1 = 5'h10;
  localparam logic [4:0]  OpIdc = 5'h01;
  localparam logic [31:0] IdVal = 32'h0000_0001;
  localparam logic [4:0]  IrCap = 5'b00101;

  logic tck_i      = 1'b0;
  logic trst_ni    = 1'b0;
  logic tms_i      = 1'b1;
  logic td_i       = 1'b0;
  logic testmode_i = 1'b0;
  logic td_o;
  logic tdo_oe_o;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic       last_tdo;
  logic       last_oe;
  logic [4:0] ir_model;

  jtag_tap_multi_if #(.IrLength(5), .NumDr(2)) dr_if ();

  jtag_tap_multi dut (
    .tck_i      (tck_i),
    .trst_ni    (trst_ni),
    .tms_i      (tms_i),
    .td_i       (td_i),
    .td_o       (td_o),
    .tdo_oe_o   (tdo_oe_o),
    .testmode_i (testmode_i),
    .dr_if      (dr_if)
  );

  always #5 tck_i = ~tck_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle; returns just after the falling edge with td_o/tdo_oe_o captured
  task automatic step(input logic tms, input logic tdi, input logic [1:0] dtdo);
    tms_i = tms;
    td_i  = tdi;
    dr_if.dr_tdo_i = dtdo;
    @(posedge tck_i); #1;
    @(negedge tck_i); #1;
    last_tdo = td_o;
    last_oe  = tdo_oe_o;
  endtask

  function automatic logic [1:0] sel_of(input logic [4:0] op);
    if (op == OpDr0)      return 2'b01;
    else if (op == OpDr1) return 2'b10;
    else                  return 2'b00;
  endfunction

  // What a DR scan must return: user channel return, IDCODE then TDI, or TDI delayed by one
  function automatic logic [63:0] exp_dr(input logic [4:0] op, input int n, input logic [63:0] din,
                                         input logic [63:0] d0, input logic [63:0] d1);
    logic [63:0] e = '0;
    for (int i = 0; i < n; i++) begin
      if (op == OpDr0)      e[i] = d0[i];
      else if (op == OpDr1) e[i] = d1[i];
      else if (op == OpIdc) begin
        if (i < 32) e[i] = IdVal[i];
        else        e[i] = din[i-32];
      end else begin
        if (i == 0) e[i] = 1'b0;
        else        e[i] = din[i-1];
      end
    end
    return e;
  endfunction

  // IR scan from RunTestIdle back to RunTestIdle
  task automatic ir_scan(input int n, input logic [15:0] din, output logic [15:0] dout);
    dout = '0;
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    chk("ir_oe_shift", 64'(last_oe), 64'd1);
    for (int i = 0; i < n; i++) begin
      dout[i] = last_tdo;
      step(i == n - 1, din[i], 2'($urandom));
    end
    chk("ir_oe_exit", 64'(last_oe), 64'd0);
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
  endtask

  // DR scan from RunTestIdle back to RunTestIdle, optionally parking in PauseDr after bit pause_at
  task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] d0,
                         input logic [63:0] d1, input int pause_at, output logic [63:0] dout);
    dout = '0;
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    chk("capture_o", 64'(dr_if.capture_o), 64'd1);
    step(1'b0, 1'b0, {d1[0], d0[0]});
    chk("shift_o", 64'(dr_if.shift_o), 64'd1);
    for (int i = 0; i < n; i++) begin
      dout[i] = last_tdo;
      chk("dr_oe_shift", 64'(last_oe), 64'd1);
      step((i == n - 1) || (i == pause_at), din[i], {d1[i+1], d0[i+1]});
      if ((i == pause_at) && (i != n - 1)) begin
        chk("dr_oe_exit1", 64'(last_oe), 64'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, {d1[i+1], d0[i+1]});
        chk("shift_o_pause", 64'(dr_if.shift_o), 64'd0);
        step(1'b1, 1'b0, {d1[i+1], d0[i+1]});
        step(1'b0, 1'b0, {d1[i+1], d0[i+1]});
      end
    end
    chk("dr_oe_exit", 64'(last_oe), 64'd0);
    step(1'b1, 1'b0, 2'b00);
    chk("update_o", 64'(dr_if.update_o), 64'd1);
    step(1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    logic [15:0] ir_in, ir_out;
    logic [63:0] din, d0, d1, dout, mask;
    int          n, p;
    logic [4:0]  op;

    dr_if.dr_tdo_i = 2'b00;
    ir_model = OpIdc;
    repeat (3) @(negedge tck_i);
    #1;
    chk("rst_td_o", 64'(td_o), 64'd0);
    chk("rst_oe", 64'(tdo_oe_o), 64'd0);
    chk("rst_tlr", 64'(dr_if.tlr_o), 64'd1);
    chk("rst_ir", 64'(dr_if.ir_o), 64'(OpIdc));
    chk("rst_strobes", 64'({dr_if.capture_o, dr_if.shift_o, dr_if.update_o}), 64'd0);
    chk("rst_sel", 64'(dr_if.dr_select_o), 64'd0);
    trst_ni = 1'b1;

    // Reset default selects IDCODE
    step(1'b0, 1'b0, 2'b00);
    chk("rti_tlr", 64'(dr_if.tlr_o), 64'd0);
    chk("rti_ir", 64'(dr_if.ir_o), 64'(OpIdc));
    din = {$urandom, $urandom};
    dr_scan(32, din, 64'd0, 64'd0, -1, dout);
    chk("idcode_read", dout & 64'hFFFF_FFFF, 64'(IdVal));

    // User channel 0
    ir_scan(5, 16'(OpDr0), ir_out);
    chk("ir_capture", 64'(ir_out[4:0]), 64'(IrCap));
    ir_model = OpDr0;
    chk("sel_dr0", 64'(dr_if.dr_select_o), 64'b01);
    d0 = 64'h5555_5555_5555_5555;
    d1 = {$urandom, $urandom};
    din = {$urandom, $urandom};
    dr_scan(8, din, d0, d1, -1, dout);
    chk("user0_read", dout & 64'hFF, exp_dr(ir_model, 8, din, d0, d1));

    // Bypass
    ir_scan(5, 16'h1f, ir_out);
    ir_model = 5'h1f;
    chk("sel_bypass", 64'(dr_if.dr_select_o), 64'b00);
    dr_scan(4, 64'b1101, 64'd0, 64'd0, -1, dout);
    chk("bypass_read", dout & 64'hF, 64'b1010);

    // Five TMS=1 from ShiftDr reach TestLogicReset
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 2'b00);
    chk("tms5_tlr", 64'(dr_if.tlr_o), 64'd1);
    step(1'b1, 1'b0, 2'b00);
    chk("tms5_ir", 64'(dr_if.ir_o), 64'(OpIdc));
    ir_model = OpIdc;
    step(1'b0, 1'b0, 2'b00);

    // Asynchronous reset in the middle of an IR shift
    ir_scan(5, 16'(OpDr1), ir_out);
    chk("sel_dr1", 64'(dr_if.dr_select_o), 64'b10);
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    chk("pre_rst_tdo", 64'({last_oe, last_tdo}), 64'b11);
    step(1'b0, 1'b1, 2'b00);
    trst_ni = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({tdo_oe_o, td_o}), 64'b00);
    chk("mid_rst_ir", 64'(dr_if.ir_o), 64'(OpIdc));
    chk("mid_rst_tlr", 64'(dr_if.tlr_o), 64'd1);
    @(negedge tck_i); #1;
    trst_ni = 1'b1;
    ir_model = OpIdc;
    step(1'b0, 1'b0, 2'b00);
    ir_scan(5, 16'(OpDr1), ir_out);
    chk("post_rst_capture", 64'(ir_out[4:0]), 64'(IrCap));
    chk("post_rst_sel", 64'(dr_if.dr_select_o), 64'b10);
    ir_model = OpDr1;

    // IDCODE readout across a PauseDr excursion
    ir_scan(5, 16'(OpIdc), ir_out);
    ir_model = OpIdc;
    din = {$urandom, $urandom};
    dr_scan(32, din, 64'd0, 64'd0, 10, dout);
    chk("idcode_pause", dout & 64'hFFFF_FFFF, 64'(IdVal));

    // Randomized IR/DR scans against the model
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 5))
        0:       op = OpDr0;
        1:       op = OpDr1;
        2:       op = OpIdc;
        3:       op = 5'h1f;
        4:       op = 5'h00;
        default: op = 5'($urandom);
      endcase
      n = $urandom_range(5, 12);
      ir_in = 16'($urandom);
      ir_in[n-1 -: 5] = op;
      ir_scan(n, ir_in, ir_out);
      mask = (64'd1 << n) - 64'd1;
      chk("rnd_ir_out", 64'(ir_out) & mask, {43'd0, ir_in, IrCap} & mask);
      ir_model = op;
      chk("rnd_ir_o", 64'(dr_if.ir_o), 64'(ir_model));
      chk("rnd_sel", 64'(dr_if.dr_select_o), 64'(sel_of(ir_model)));

      n = $urandom_range(1, 40);
      p = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      din = {$urandom, $urandom};
      d0  = {$urandom, $urandom};
      d1  = {$urandom, $urandom};
      dr_scan(n, din, d0, d1, p, dout);
      mask = (64'd1 << n) - 64'd1;
      chk("rnd_dr_out", dout & mask, exp_dr(ir_model, n, din, d0, d1));

      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 2'b00);
        chk("rnd_tlr", 64'(dr_if.tlr_o), 64'd1);
        step(1'b0, 1'b0, 2'b00);
        ir_model = OpIdc;
        chk("rnd_tlr_ir", 64'(dr_if.ir_o), 64'(ir_model));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_multi.md
Name: jtag_tap_multi

Overview:
Parametrised IEEE 1149.1 TAP controller, the successor of the single-purpose DMI TAP.
- Supports a configurable IR length, IR capture pattern, IDCODE opcode and value.
- Supports NumDr user data-register channels, each decoded from its own opcode and given its own select and TDO return path.
- Sits between the JTAG pads and DTM-style custom DR logic (DMI, DTMCS, trace, vendor registers).
- Resets into TestLogicReset, per the standard.

Parameters:
IrLength, 5, instruction register width (>= 2)
NumDr, 2, number of user DR channels (>= 1)
DrOpcodes, {5'h11, 5'h10}, array [NumDr] of IrLength-bit opcodes; index i selects channel i
IdcodeOpcode, 5'h01, opcode selecting IDCODE; also the IR value after reset and in TestLogicReset
IdcodeValue, 32'h00000001, IDCODE content; bit 0 must be 1
IrCaptureValue, 5'b00101, loaded into IR shift register in CaptureIr; bits [1:0] must be 2'b01

Ports:
tck_i  in  1  JTAG test clock (the only clock)
trst_ni  in  1  asynchronous active-low reset
tms_i  in  1  test mode select
td_i  in  1  test data in
td_o  out  1  test data out, launched on falling tck_i
tdo_oe_o  out  1  TDO output enable, launched on falling tck_i
testmode_i  in  1  DFT: 1 = falling-edge flops clocked by non-inverted tck_i
tck_o  out  1  tck_i feed-through
tdi_o  out  1  td_i feed-through
capture_o  out  1  TAP in CaptureDr
shift_o  out  1  TAP in ShiftDr
update_o  out  1  TAP in UpdateDr
tlr_o  out  1  TAP in TestLogicReset (synchronous clear for user logic)
dr_select_o  out  NumDr  one-hot (or zero) user-channel select, decoded from IR
dr_tdo_i  in  NumDr  per-channel serial data return
ir_o  out  IrLength  current instruction register

Behaviour:
- Reset (trst_ni low, asynchronous):
  - tap state = TestLogicReset; ir_q = IdcodeOpcode; IR shift = 0; idcode shift = IdcodeValue; bypass = 0.
  - td_o = 0; tdo_oe_o = 0.
  - tlr_o = 1 while in TestLogicReset; all other strobes 0.
- FSM: 16 standard states, advancing on rising tck_i with standard TMS transitions.
  - Five consecutive TMS=1 cycles reach TestLogicReset from any state.
  - Strobes are combinational decodes of the current state.
- IR path:
  - CaptureIr: shift <= IrCaptureValue.
  - ShiftIr: shift <= {td_i, shift[IrLength-1:1]} (LSB first).
  - UpdateIr: ir_q <= shift.
  - TestLogicReset: ir_q <= IdcodeOpcode; this has priority over update.
  - Pause/Exit states hold all IR registers.
- Decode:
  - dr_select_o[i] = (ir_q == DrOpcodes[i]). On duplicate opcodes only the lowest index asserts.
  - ir_q == IdcodeOpcode selects the internal 32-bit IDCODE register.
  - Any other value, including all-ones and all-zeros, selects the 1-bit bypass register.
  - User opcodes take precedence over IdcodeOpcode if equal.
- Internal DRs:
  - CaptureDr: IDCODE register <= IdcodeValue; bypass <= 0.
  - ShiftDr: IDCODE register shifts right with td_i into the MSB; bypass <= td_i.
  - Each register is written only while selected.
- TDO mux:
  - ShiftIr: IR shift[0].
  - Otherwise: selected user dr_tdo_i[i], else idcode[0], else bypass.
- td_o / tdo_oe_o:
  - Registered on the falling edge of tck_i, with tck_i inverted through tc_clk_inverter plus tc_clk_mux2 bypass on testmode_i.
  - tdo_oe_o = ShiftIr | ShiftDr.
  - The first shifted bit therefore appears half a cycle after entering the shift state.
- Mid-operation reset: state, IR and outputs return to reset values immediately; a partial shift is discarded.
- Mid-scan IR change: impossible, since ir_q changes only in UpdateIr or TestLogicReset.

Test Plan:
1. Release trst_ni, TMS=0 for 1 cycle -> RunTestIdle; ir_o=5'h01; DR scan of 32 bits returns 0x00000001 LSB first; tdo_oe_o high only during ShiftDr.
2. IR scan shifting 5'h11 -> TDO returns capture pattern 1,0,1,0,0 (LSB first); after UpdateIr, dr_select_o=2'b01; 8-bit DR scan with dr_tdo_i[0] toggling -> td_o mirrors it half a cycle later; capture/shift/update_o pulse in the matching states.
3. IR scan 5'h1f, then DR scan of pattern 1011 -> td_o returns 0 then 1,0,1 (1-bit delay); dr_select_o=0.
4. From ShiftDr, hold TMS=1 for 5 cycles -> TestLogicReset; tlr_o=1; ir_o=5'h01 regardless of the prior IR.
5. Assert trst_ni mid-ShiftIr -> td_o=0, tdo_oe_o=0 and ir_o=5'h01 immediately; next scan starts clean.
6. ShiftDr→Exit1Dr→PauseDr (3 cycles)→Exit2Dr→ShiftDr on IDCODE -> the 32-bit readout is uninterrupted and correct; shift_o low during the pause.
